// File: rtl/reg_file_mp_pkg.sv
// Shared defaults for the multi-port register file: data/address widths and
// the hardwired-zero register address.
package reg_file_mp_pkg;
  localparam int DEFAULT_DATA_W = 64;
  localparam int DEFAULT_ADDR_W = 5;
  localparam int unsigned ZERO_ADDR = 0;
endpackage

// File: rtl/rf_read_port.sv
// One read port: register select, write-first bypass (wb over wa), and the
// registered data/valid/busy outputs. One-cycle latency, no backpressure.
module rf_read_port
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rd_en,
  input  logic [ADDR_W-1:0]         rd_addr,
  input  logic [DEPTH*DATA_W-1:0]   regs_flat,
  input  logic [DEPTH-1:0]          pending,
  input  logic                      wa_en,
  input  logic [ADDR_W-1:0]         wa_addr,
  input  logic [DATA_W-1:0]         wa_data,
  input  logic                      wb_en,
  input  logic [ADDR_W-1:0]         wb_addr,
  input  logic [DATA_W-1:0]         wb_data,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      rd_valid,
  output logic                      rd_busy
);
  logic              addr_nz;
  logic              wb_hit;
  logic              wa_hit;
  logic [DATA_W-1:0] data_next;
  logic              busy_next;

  assign addr_nz = (rd_addr != ADDR_W'(ZERO_ADDR));
  assign wb_hit  = wb_en && (wb_addr == rd_addr) && addr_nz;
  assign wa_hit  = wa_en && (wa_addr == rd_addr) && addr_nz;

  always_comb begin
    data_next = '0;
    if (wb_hit)
      data_next = wb_data;
    else if (wa_hit)
      data_next = wa_data;
    else if (addr_nz)
      data_next = regs_flat[rd_addr*DATA_W +: DATA_W];
  end

  // A writeback landing this cycle resolves the hazard before the read returns.
  assign busy_next = pending[rd_addr] && !wb_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_busy  <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= data_next;
        rd_busy <= busy_next;
      end
    end
  end
endmodule

// File: rtl/reg_file_mp.sv
// Register file with two write ports (ALU, load writeback), load-pending
// scoreboard and NUM_RD independent one-cycle read ports.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wa_en,
  input  logic [ADDR_W-1:0]        wa_addr,
  input  logic [DATA_W-1:0]        wa_data,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] regs_q;
  logic [DEPTH-1:0]             pending_q;
  logic [DEPTH*DATA_W-1:0]      regs_flat;

  assign regs_flat = regs_q;

  // Entry 0 is never written, so it stays zero and never becomes pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q    <= '0;
      pending_q <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (wb_en && wb_addr == ADDR_W'(i))
          regs_q[i] <= wb_data;
        else if (wa_en && wa_addr == ADDR_W'(i))
          regs_q[i] <= wa_data;

        if (iss_en && iss_addr == ADDR_W'(i))
          pending_q[i] <= 1'b1;
        else if (wb_en && wb_addr == ADDR_W'(i))
          pending_q[i] <= 1'b0;
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    rf_read_port #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .DEPTH (DEPTH)
    ) u_port (
      .clk      (clk),
      .rst      (rst),
      .rd_en    (rd_en[p]),
      .rd_addr  (rd_addr[p*ADDR_W +: ADDR_W]),
      .regs_flat(regs_flat),
      .pending  (pending_q),
      .wa_en    (wa_en),
      .wa_addr  (wa_addr),
      .wa_data  (wa_data),
      .wb_en    (wb_en),
      .wb_addr  (wb_addr),
      .wb_data  (wb_data),
      .rd_data  (rd_data[p*DATA_W +: DATA_W]),
      .rd_valid (rd_valid[p]),
      .rd_busy  (rd_busy[p])
    );
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: reset, bypass, write priority, pending
// scoreboard and mid-traffic reset, each scenario in its own task.
module tb_reg_file_mp;
  localparam int DW = 64;
  localparam int AW = 5;
  localparam int NR = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] rd_en;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0] rd_valid;
  logic [NR-1:0] rd_busy;
  logic          wa_en, wb_en, iss_en;
  logic [AW-1:0] wa_addr, wb_addr, iss_addr;
  logic [DW-1:0] wa_data, wb_data;

  int n_cmp = 0;
  int n_err = 0;

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clk(clk), .rst(rst),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_busy(rd_busy),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .iss_en(iss_en), .iss_addr(iss_addr)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_en = '0; wa_en = 0; wb_en = 0; iss_en = 0;
  endtask

  task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_en = 2'b11;
    rd_addr = {a1, a0};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    rd_addr = '0; wa_addr = '0; wb_addr = '0; iss_addr = '0;
    wa_data = '0; wb_data = '0;
    #3;
    n_cmp++; if (rd_data !== '0) begin n_err++; $display("FAIL reset_data got %h want 0", rd_data); end
    n_cmp++; if (rd_valid !== 2'b00) begin n_err++; $display("FAIL reset_valid got %b want 00", rd_valid); end
    n_cmp++; if (rd_busy !== 2'b00) begin n_err++; $display("FAIL reset_busy got %b want 00", rd_busy); end
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_read_all();
    for (int a = 0; a < 32; a++) begin
      rd(AW'(a), AW'(31 - a));
      cycle();
      idle();
      n_cmp++; if (rd_valid !== 2'b11) begin n_err++; $display("FAIL all_valid a=%0d got %b want 11", a, rd_valid); end
      n_cmp++; if (rd_data !== '0 || rd_busy !== 2'b00) begin n_err++; $display("FAIL all_data a=%0d got %h/%b want 0/00", a, rd_data, rd_busy); end
      cycle();
      n_cmp++; if (rd_valid !== 2'b00) begin n_err++; $display("FAIL all_novalid a=%0d got %b want 00", a, rd_valid); end
    end
  endtask

  task automatic test_bypass();
    wa_en = 1; wa_addr = 5; wa_data = 64'h1234;
    rd(5, 5);
    cycle();
    wa_en = 1; wa_addr = 0; wa_data = 64'hFF;
    rd(0, 5);
    n_cmp++; if (rd_data[DW-1:0] !== 64'h1234) begin n_err++; $display("FAIL bypass_p0 got %h want 1234", rd_data[DW-1:0]); end
    n_cmp++; if (rd_data[2*DW-1:DW] !== 64'h1234) begin n_err++; $display("FAIL bypass_p1 got %h want 1234", rd_data[2*DW-1:DW]); end
    cycle();
    idle();
    n_cmp++; if (rd_data[DW-1:0] !== '0) begin n_err++; $display("FAIL zero_bypass got %h want 0", rd_data[DW-1:0]); end
    n_cmp++; if (rd_data[2*DW-1:DW] !== 64'h1234) begin n_err++; $display("FAIL stored_5 got %h want 1234", rd_data[2*DW-1:DW]); end
    cycle();
    n_cmp++; if (rd_data[DW-1:0] !== '0) begin n_err++; $display("FAIL hold_data got %h want 0", rd_data[DW-1:0]); end
    rd(0, 0);
    cycle();
    idle();
    n_cmp++; if (rd_data !== '0) begin n_err++; $display("FAIL zero_reg got %h want 0", rd_data); end
  endtask

  task automatic test_write_priority();
    wa_en = 1; wa_addr = 7; wa_data = 64'hAAAA;
    wb_en = 1; wb_addr = 7; wb_data = 64'hBBBB;
    rd(7, 6);
    cycle();
    idle();
    n_cmp++; if (rd_data[DW-1:0] !== 64'hBBBB) begin n_err++; $display("FAIL prio_bypass got %h want bbbb", rd_data[DW-1:0]); end
    rd(7, 7);
    cycle();
    idle();
    n_cmp++; if (rd_data !== {64'hBBBB, 64'hBBBB}) begin n_err++; $display("FAIL prio_stored got %h want bbbb x2", rd_data); end
  endtask

  task automatic test_pending();
    iss_en = 1; iss_addr = 9;
    rd(9, 9);
    cycle();
    idle();
    n_cmp++; if (rd_busy !== 2'b00) begin n_err++; $display("FAIL busy_same_cycle got %b want 00", rd_busy); end
    rd(9, 8);
    cycle();
    idle();
    n_cmp++; if (rd_busy !== 2'b01) begin n_err++; $display("FAIL busy_set got %b want 01", rd_busy); end
    wb_en = 1; wb_addr = 9; wb_data = 64'h55;
    rd(9, 9);
    cycle();
    idle();
    n_cmp++; if (rd_data !== {64'h55, 64'h55} || rd_busy !== 2'b00) begin n_err++; $display("FAIL wb_clear got %h/%b want 55x2/00", rd_data, rd_busy); end
    rd(9, 9);
    cycle();
    idle();
    n_cmp++; if (rd_busy !== 2'b00) begin n_err++; $display("FAIL busy_after_wb got %b want 00", rd_busy); end
  endtask

  task automatic test_iss_wb_same();
    iss_en = 1; iss_addr = 3;
    wb_en = 1; wb_addr = 3; wb_data = 64'h33;
    cycle();
    idle();
    rd(3, 3);
    cycle();
    idle();
    n_cmp++; if (rd_busy !== 2'b11 || rd_data[DW-1:0] !== 64'h33) begin n_err++; $display("FAIL iss_wins got %b/%h want 11/33", rd_busy, rd_data[DW-1:0]); end
    wa_en = 1; wa_addr = 3; wa_data = 64'h44;
    cycle();
    idle();
    iss_en = 1; iss_addr = 3;
    rd(3, 0);
    cycle();
    idle();
    n_cmp++; if (rd_busy !== 2'b01 || rd_data[DW-1:0] !== 64'h44) begin n_err++; $display("FAIL wa_keeps_busy got %b/%h want 01/44", rd_busy, rd_data[DW-1:0]); end
    rd(3, 3);
    cycle();
    idle();
    n_cmp++; if (rd_busy !== 2'b11) begin n_err++; $display("FAIL reissue_busy got %b want 11", rd_busy); end
  endtask

  task automatic test_reset_mid();
    for (int a = 1; a < 32; a++) begin
      wa_en = 1; wa_addr = AW'(a); wa_data = 64'h1111 * a;
      cycle();
    end
    idle();
    iss_en = 1; iss_addr = 12;
    cycle();
    idle();
    rd(12, 31);
    cycle();
    n_cmp++; if (rd_data !== {64'h1111 * 31, 64'h1111 * 12} || rd_busy !== 2'b01) begin n_err++; $display("FAIL pre_reset got %h/%b want data/01", rd_data, rd_busy); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (rd_data !== '0 || rd_valid !== 2'b00 || rd_busy !== 2'b00) begin n_err++; $display("FAIL async_reset got %h/%b/%b want 0", rd_data, rd_valid, rd_busy); end
    wa_en = 1; wa_addr = 4; wa_data = 64'hDEAD;
    iss_en = 1; iss_addr = 4;
    rd(4, 4);
    cycle();
    n_cmp++; if (rd_valid !== 2'b00 || rd_data !== '0) begin n_err++; $display("FAIL read_in_reset got %b/%h want 00/0", rd_valid, rd_data); end
    idle();
    rst = 1'b0;
    for (int a = 0; a < 32; a++) begin
      rd(AW'(a), AW'(a));
      cycle();
      idle();
      n_cmp++; if (rd_data !== '0 || rd_busy !== 2'b00 || rd_valid !== 2'b11) begin n_err++; $display("FAIL post_reset a=%0d got %h/%b/%b want 0/00/11", a, rd_data, rd_busy, rd_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_read_all();
    test_bypass();
    test_write_priority();
    test_pending();
    test_iss_wb_same();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
